// File: rtl/ram_rd_pkg.sv
// Shared types and sizing helpers for the block RAM reader.
package ram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // Count width must hold 0..depth inclusive.
  function automatic int fifo_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO holding returned RAM words plus their last tag.
module ram_rd_fifo import ram_rd_pkg::*; #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  parameter int CW    = fifo_count_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ram_dp_block_reader.sv
// Block-read initiator: issues one RAM read per cycle under a FIFO credit
// limit and streams the returned words in order with last/done framing.
module ram_dp_block_reader import ram_rd_pkg::*; #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int LEN_WIDTH    = 11,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_rdaddress,
  output logic                  ram_rden,
  output logic                  ram_rdclken,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = fifo_count_width(FIFO_DEPTH);

  rd_state_t             state;
  rd_state_t             state_next;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  zero_done;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_last;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credit;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH:0]   fifo_head;
  logic                  accept;
  logic                  issue;
  logic                  issue_last;
  logic                  pop;
  logic                  push;

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // valid never depends on ready, and held data stays stable until accepted.
  assign accept     = cmd_valid && cmd_ready;
  assign pop        = out_valid && out_ready;
  assign push       = pipe_valid[READ_LATENCY-1];
  assign issue_last = issue && (remaining == LEN_WIDTH'(1));
  assign credit     = {1'b0, fifo_count} + {1'b0, inflight};

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(pipe_valid[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && cmd_len != '0) state_next = ISSUE;
      ISSUE:   if (issue_last)              state_next = DRAIN;
      DRAIN:   if (pop && out_last)         state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  // Credit uses registered occupancy only, so a same-cycle pop is not counted.
  always_comb begin
    cmd_ready = (state == IDLE) && !reset;
    busy      = (state != IDLE);
    issue     = (state == ISSUE) && (remaining != '0) &&
                (credit < (CW+1)'(FIFO_DEPTH));
    done      = zero_done || ((state == DRAIN) && pop && out_last);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_addr   <= '0;
      remaining  <= '0;
      zero_done  <= 1'b0;
      pipe_valid <= '0;
      pipe_last  <= '0;
    end else begin
      zero_done <= accept && (cmd_len == '0);
      if (accept) begin
        cur_addr  <= cmd_addr;
        remaining <= cmd_len;
      end else if (issue) begin
        cur_addr  <= cur_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      pipe_valid[0] <= issue;
      pipe_last[0]  <= issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
    end
  end

  assign ram_rden      = issue;
  assign ram_rdaddress = cur_addr;
  assign ram_rdclken   = 1'b1;

  ram_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({pipe_last[READ_LATENCY-1], ram_q}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[DATA_WIDTH-1:0];
  assign out_last  = !fifo_empty && fifo_head[DATA_WIDTH];

  // The credit limit makes a push into a full FIFO impossible.
  always_ff @(posedge clock) begin
    if (!reset) assert (!(push && fifo_full && !pop));
  end

endmodule
